// File: rtl/host_arbiter_if.sv
// Bundle of requester-side and bus-side signals of the host arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface host_arbiter_if #(
  parameter int NrHosts      = 2,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
);
  logic [NrHosts-1:0]              host_req_i;
  logic [NrHosts-1:0]              host_gnt_o;
  logic [NrHosts*AddressWidth-1:0] host_addr_i;
  logic [NrHosts-1:0]              host_we_i;
  logic [NrHosts*4-1:0]            host_be_i;
  logic [NrHosts*DataWidth-1:0]    host_wdata_i;
  logic [NrHosts-1:0]              host_rvalid_o;
  logic [DataWidth-1:0]            host_rdata_o;
  logic                            host_err_o;

  logic                            bus_req_o;
  logic                            bus_gnt_i;
  logic [AddressWidth-1:0]         bus_addr_o;
  logic                            bus_we_o;
  logic [3:0]                      bus_be_o;
  logic [DataWidth-1:0]            bus_wdata_o;
  logic                            bus_rvalid_i;
  logic [DataWidth-1:0]            bus_rdata_i;
  logic                            bus_err_i;

  modport slave (
    input  host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
    output host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    output bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o
  );

  modport master (
    output host_req_i, host_addr_i, host_we_i, host_be_i, host_wdata_i,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
    input  host_gnt_o, host_rvalid_o, host_rdata_o, host_err_o,
    input  bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o
  );
endinterface

// File: rtl/host_arbiter.sv
// Round-robin arbiter sharing one bus host port among NrHosts requesters, one transaction in flight.
// Optional response watchdog enabled by defining HOST_ARB_TIMEOUT_EN.
module host_arbiter #(
  parameter int NrHosts       = 2,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 255
) (
  input logic           clk_i,
  input logic           rst_i,
  host_arbiter_if.slave arb_if
);
  localparam int IdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;

  if (NrHosts < 2) begin : g_chk_hosts
    $error("host_arbiter: NrHosts must be at least 2");
  end
  if (TimeoutCycles < 1 || TimeoutCycles > 65535) begin : g_chk_timeout
    $error("host_arbiter: TimeoutCycles must be in 1..65535");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         ptr_q, ptr_d, idx_q, idx_d, sel_idx;
  logic                    sel_vld;
  logic [AddressWidth-1:0] addr_q, addr_d;
  logic                    we_q, we_d;
  logic [3:0]              be_q, be_d;
  logic [DataWidth-1:0]    wdata_q, wdata_d;
  logic [NrHosts-1:0]      rvalid_q, rvalid_d;
  logic [DataWidth-1:0]    rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [NrHosts-1:0]      gnt;
`ifdef HOST_ARB_TIMEOUT_EN
  logic [15:0]             cnt_q, cnt_d;
`endif

  function automatic logic [IdxW-1:0] wrap_idx(input int v);
    return (v >= NrHosts) ? IdxW'(v - NrHosts) : IdxW'(v);
  endfunction

  // Walk downward so the closest requester at or after ptr wins.
  always_comb begin
    sel_idx = '0;
    sel_vld = 1'b0;
    for (int k = NrHosts - 1; k >= 0; k--) begin
      if (arb_if.host_req_i[wrap_idx(int'(ptr_q) + k)]) begin
        sel_idx = wrap_idx(int'(ptr_q) + k);
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    we_d     = we_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    gnt      = '0;
`ifdef HOST_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          idx_d   = sel_idx;
          addr_d  = arb_if.host_addr_i[sel_idx*AddressWidth +: AddressWidth];
          we_d    = arb_if.host_we_i[sel_idx];
          be_d    = arb_if.host_be_i[sel_idx*4 +: 4];
          wdata_d = arb_if.host_wdata_i[sel_idx*DataWidth +: DataWidth];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (arb_if.bus_gnt_i) begin
          gnt[idx_q] = 1'b1;
          ptr_d      = wrap_idx(int'(idx_q) + 1);
          state_d    = WAIT_RSP;
`ifdef HOST_ARB_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      WAIT_RSP: begin
        if (arb_if.bus_rvalid_i) begin
          rvalid_d[idx_q] = 1'b1;
          rdata_d         = arb_if.bus_rdata_i;
          err_d           = arb_if.bus_err_i;
          state_d         = IDLE;
        end
`ifdef HOST_ARB_TIMEOUT_EN
        // Watchdog: answer the requester ourselves with an error after TimeoutCycles silent cycles.
        else if (cnt_q == 16'(TimeoutCycles - 1)) begin
          rvalid_d[idx_q] = 1'b1;
          rdata_d         = '0;
          err_d           = 1'b1;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef HOST_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef HOST_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign arb_if.bus_req_o     = (state_q == ISSUE);
  assign arb_if.bus_addr_o    = addr_q;
  assign arb_if.bus_we_o      = we_q;
  assign arb_if.bus_be_o      = be_q;
  assign arb_if.bus_wdata_o   = wdata_q;
  assign arb_if.host_gnt_o    = gnt;
  assign arb_if.host_rvalid_o = rvalid_q;
  assign arb_if.host_rdata_o  = rdata_q;
  assign arb_if.host_err_o    = err_q;
endmodule
